// File: rtl/kernel_wrapper_example_stream_source_pkg.sv
// Shared types and helpers for the example stream source/checker pair.
// Holds the FSM encoding, lane/byte derivations and the tail keep mask.
package kernel_wrapper_example_stream_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Widest keep mask the helper can build (2048-bit stream).
  localparam int unsigned C_MAX_BPB = 256;

  function automatic int unsigned lanes_of(
    input int unsigned data_w,
    input int unsigned lane_w
  );
    return data_w / lane_w;
  endfunction

  function automatic int unsigned bpb_of(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Low rem bits set; all ones when rem is zero (full final beat).
  // Callers truncate to their own keep width.
  function automatic logic [C_MAX_BPB-1:0] keep_mask(
    input logic [31:0] rem
  );
    logic [C_MAX_BPB-1:0] m;
    m = '1;
    if (rem != 32'd0 && rem < 32'(C_MAX_BPB))
      m = m >> (32'(C_MAX_BPB) - rem);
    return m;
  endfunction

endpackage

// File: rtl/kernel_wrapper_example_stream_source_if.sv
// AXI4-Stream bundle between the pattern source and its consumer.
// master drives valid/data/keep/last; slave drives ready.
interface kernel_wrapper_example_stream_source_if #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 512
);
  logic                            tvalid;
  logic                            tready;
  logic [C_AXIS_TDATA_WIDTH-1:0]   tdata;
  logic [C_AXIS_TDATA_WIDTH/8-1:0] tkeep;
  logic                            tlast;

  modport master (
    output tvalid, tdata, tkeep, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast,
    output tready
  );
endinterface

// File: rtl/kernel_wrapper_example_pattern_lanes.sv
// Per-lane counting pattern register: load seed+k, advance by LANES.
// Ports: clk/rst, load+seed start a message, adv steps every lane.
module kernel_wrapper_example_pattern_lanes
  import kernel_wrapper_example_stream_source_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
  parameter int unsigned C_ADDER_BIT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic                          adv,
  input  logic [C_ADDER_BIT_WIDTH-1:0]  seed,
  output logic [C_AXIS_TDATA_WIDTH-1:0] data
);

  localparam int unsigned LANES =
    lanes_of(C_AXIS_TDATA_WIDTH, C_ADDER_BIT_WIDTH);
  localparam int unsigned AW = C_ADDER_BIT_WIDTH;

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      for (int k = 0; k < LANES; k++)
        data[k*AW +: AW] <= seed + AW'(k);
    end else if (adv) begin
      for (int k = 0; k < LANES; k++)
        data[k*AW +: AW] <= data[k*AW +: AW] + AW'(LANES);
    end
  end

endmodule

// File: rtl/kernel_wrapper_example_stream_source.sv
// AXIS counting-pattern source feeding the pipelined adder kernel.
// Ports: clk/reset, ctrl start/len/seed/busy/done, m_axis master.
module kernel_wrapper_example_stream_source
  import kernel_wrapper_example_stream_source_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
  parameter int unsigned C_ADDER_BIT_WIDTH  = 32,
  parameter int unsigned C_LENGTH_WIDTH     = 32
) (
  input  logic                         m_axis_aclk,
  input  logic                         m_axis_areset,
  input  logic                         ctrl_start,
  input  logic [C_LENGTH_WIDTH-1:0]    ctrl_length_bytes,
  input  logic [C_ADDER_BIT_WIDTH-1:0] ctrl_seed,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
  kernel_wrapper_example_stream_source_if.master m_axis
);

  localparam int unsigned BPB = bpb_of(C_AXIS_TDATA_WIDTH);
  localparam int unsigned LW  = C_LENGTH_WIDTH;
  localparam logic [LW-1:0] BPB_L = LW'(BPB);

  state_e          state;
  logic [LW-1:0]   beats_left;
  logic [LW-1:0]   rem;
  logic            tvalid;
  logic            tlast;
  logic [BPB-1:0]  tkeep;

  logic [LW-1:0]   len_rem;
  logic [LW-1:0]   len_beats;
  logic [BPB-1:0]  keep_new;
  logic [BPB-1:0]  keep_cur;
  logic            fire;
  logic            last_fire;
  logic            load;

  // Division by a constant; avoids the len+BPB-1 overflow at max len.
  assign len_rem   = ctrl_length_bytes % BPB_L;
  assign len_beats = ctrl_length_bytes / BPB_L
                   + LW'(len_rem != '0);

  assign keep_new = BPB'(keep_mask(32'(len_rem)));
  assign keep_cur = BPB'(keep_mask(32'(rem)));

  assign fire      = (state == ST_RUN) && tvalid && m_axis.tready;
  assign last_fire = fire && (beats_left == LW'(1));
  assign load      = (state == ST_IDLE) && ctrl_start
                   && (ctrl_length_bytes != '0);

  kernel_wrapper_example_pattern_lanes #(
    .C_AXIS_TDATA_WIDTH (C_AXIS_TDATA_WIDTH),
    .C_ADDER_BIT_WIDTH  (C_ADDER_BIT_WIDTH)
  ) u_lanes (
    .clk  (m_axis_aclk),
    .rst  (m_axis_areset),
    .load (load),
    .adv  (fire && !last_fire),
    .seed (ctrl_seed),
    .data (m_axis.tdata)
  );

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      state      <= ST_IDLE;
      beats_left <= '0;
      rem        <= '0;
      tvalid     <= 1'b0;
      tlast      <= 1'b0;
      tkeep      <= '0;
      ctrl_busy  <= 1'b0;
      ctrl_done  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          ctrl_done <= 1'b0;
          if (ctrl_start) begin
            ctrl_busy <= 1'b1;
            if (ctrl_length_bytes == '0) begin
              state     <= ST_DONE;
              ctrl_done <= 1'b1;
            end else begin
              state      <= ST_RUN;
              beats_left <= len_beats;
              rem        <= len_rem;
              tvalid     <= 1'b1;
              tlast      <= (len_beats == LW'(1));
              tkeep      <= (len_beats == LW'(1))
                          ? keep_new : '1;
            end
          end
        end
        ST_RUN: begin
          if (last_fire) begin
            state     <= ST_DONE;
            tvalid    <= 1'b0;
            tlast     <= 1'b0;
            tkeep     <= '0;
            ctrl_done <= 1'b1;
          end else if (fire) begin
            beats_left <= beats_left - LW'(1);
            tlast      <= (beats_left == LW'(2));
            tkeep      <= (beats_left == LW'(2))
                        ? keep_cur : '1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          ctrl_done <= 1'b0;
          ctrl_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_axis.tvalid = tvalid;
  assign m_axis.tlast  = tlast;
  assign m_axis.tkeep  = tkeep;

endmodule

// File: doc/kernel_wrapper_example_stream_source.md
Name: kernel_wrapper_example_stream_source

Overview:
AXI4-Stream transmitter that produces the input stream for the pipelined adder kernel. On a start pulse it emits a message of ctrl_length_bytes bytes as full-width beats carrying a deterministic counting pattern. TKEEP is set correctly on the final beat, and TLAST is asserted on that beat. It sits upstream of the adder's s_axis port. Because the pattern is known, a downstream checker can predict every adder output lane as pattern + constant.

Parameters:
C_AXIS_TDATA_WIDTH, 512, stream data width in bits; multiple of C_ADDER_BIT_WIDTH and of 8.
C_ADDER_BIT_WIDTH, 32, pattern lane width in bits; matches the adder lane width.
C_LENGTH_WIDTH, 32, width of the byte-length input.

Ports:
m_axis_aclk  in  1  sole clock
m_axis_areset  in  1  synchronous reset, active-high
ctrl_start  in  1  single-cycle start request; sampled only in IDLE
ctrl_length_bytes  in  C_LENGTH_WIDTH  message length in bytes; sampled with ctrl_start
ctrl_seed  in  C_ADDER_BIT_WIDTH  pattern seed; sampled with ctrl_start
ctrl_busy  out  1  high in RUN and DONE
ctrl_done  out  1  one-cycle completion pulse
m_axis_tvalid  out  1  AXIS valid
m_axis_tready  in  1  AXIS ready
m_axis_tdata  out  C_AXIS_TDATA_WIDTH  pattern data
m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  byte enables
m_axis_tlast  out  1  final beat of message

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (m_axis_aclk, m_axis_areset).
- Derived constants: LANES = C_AXIS_TDATA_WIDTH/C_ADDER_BIT_WIDTH; BPB = C_AXIS_TDATA_WIDTH/8.
- Reset values: state IDLE; m_axis_tvalid, m_axis_tlast, ctrl_busy, ctrl_done = 0; m_axis_tkeep = 0; m_axis_tdata = 0.
- Reset mid-message: the message is dropped; tvalid is 0 after the reset edge. No flush; downstream shares the reset.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: on ctrl_start with length > 0.
  - At that edge load beats_left = ceil(len/BPB) and rem = len mod BPB.
  - Load tdata lane k = seed + k (mod 2^C_ADDER_BIT_WIDTH).
  - Assert tvalid, so the first beat is valid the cycle after start (latency 1).
  - tlast and tkeep for that beat follow the rules below.
- IDLE -> DONE: on ctrl_start with length = 0. No beat is emitted.
- RUN, beat rules:
  - A beat transfers on an edge with tvalid & tready.
  - tdata, tkeep, tlast are held stable while tvalid=1 and tready=0.
  - On each transfer that is not the last: every lane += LANES (wraps modulo 2^C_ADDER_BIT_WIDTH), beats_left decrements, tvalid stays 1.
  - Throughput is 1 beat/cycle with tready held high; there is no bubble between beats.
  - tlast = (beats_left == 1).
  - tkeep is all ones, except on the last beat when rem != 0: then the low rem bits are set and the rest are 0.
- RUN -> DONE: on the edge where the last beat transfers. tvalid and tlast fall to 0 at that edge.
- DONE: ctrl_done = 1 for exactly one cycle, then the FSM returns to IDLE.
- Start handling:
  - ctrl_start in RUN or DONE is ignored, not queued.
  - A start is accepted in the first IDLE cycle after DONE.
- Outputs are registered; there is no combinational path from tready to tvalid/tdata.
- Width rules: beats_left is C_LENGTH_WIDTH bits. Lane arithmetic is unsigned and truncating.

Decomposition:
- Shared package:
  - state encoding (IDLE/RUN/DONE);
  - LANES and BPB derivation functions;
  - a keep_mask(rem) function returning the low-rem-bits mask (all ones when rem = 0).
- The same package serves a future stream checker.
- One sub-module is natural: kernel_wrapper_example_pattern_lanes, the per-lane registered seed-load/increment datapath.
- FSM, counters and AXIS handshake stay in the top.

Test Plan (W=512, lane 32; LANES=16, BPB=64):
- len=128, seed=0, tready=1: start cycle 0 -> beats at cycles 1 and 2.
  - Beat 0: lanes 0..15; beat 1: lanes 16..31.
  - tkeep all ones on both; tlast on beat 1 only.
  - ctrl_done=1 at cycle 3; busy high cycles 1–3.
- len=100, seed=5: 2 beats.
  - Beat 1 lanes 21..36.
  - Beat 1 tkeep = low 36 bits set (0x0000000FFFFFFFFF in a 64-bit mask); tlast=1.
- len=0: no tvalid ever; ctrl_done=1 at cycle 1; IDLE at cycle 2.
- len=192, tready toggling 1,0,0,1,1: 3 beats.
  - Data, tkeep and tlast are stable while stalled.
  - Lane 0 sequence is seed, seed+16, seed+32; no beat is lost or duplicated.
- seed=0xFFFFFFF8, len=64: lane k = 0xFFFFFFF8 + k. Lanes 8..15 wrap to 0..7.
- Mid-message:
  - ctrl_start asserted during RUN is ignored: the message length and data are unchanged.
  - m_axis_areset asserted during RUN with tready=1: tvalid=0, busy=0, done=0 after the reset edge.
  - A subsequent start behaves normally.
